// File: rtl/flag_writer_if.sv
// Update-request channel between the hash-table update logic and flag_writer.
// A request transfers on a rising edge where req_valid_i && req_ready_o and clear_i is low; the requester holds op/adr/slot stable while req_valid_i is high, and resp_valid_o is a one-cycle completion pulse with no backpressure.
interface flag_writer_if #(
  parameter int SIZE        = 10,
  parameter int BUCKET_SIZE = 4,
  parameter int SLOT_W      = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_op_i;
  logic [SIZE-1:0]   req_adr_i;
  logic [SLOT_W-1:0] req_slot_i;
  logic              resp_valid_o;
  logic              resp_err_o;

  modport master (
    output req_valid_i, req_op_i, req_adr_i, req_slot_i,
    input  req_ready_o, resp_valid_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_adr_i, req_slot_i,
    output req_ready_o, resp_valid_o, resp_err_o
  );
endinterface

// File: rtl/flag_writer.sv
// Write-side controller for the bucket valid-flag memory: read-modify-write of
// single slot flags, plus a full zeroing sweep after reset or on clear_i.
module flag_writer #(
  parameter int SIZE        = 10,
  parameter int BUCKET_SIZE = 4,
  parameter int SLOT_W      = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  flag_writer_if.slave           req_if,
  output logic [SIZE-1:0]        rd_adr_o,
  input  logic [BUCKET_SIZE-1:0] rd_flag_i,
  output logic [SIZE-1:0]        write_adr_o,
  output logic                   write_en_o,
  output logic [BUCKET_SIZE-1:0] write_is_valid_o,
  output logic                   init_done_o,
  output logic [2:0]             dbg_state_o
);

  typedef enum logic [2:0] {
    CLEAR  = 3'd0,
    IDLE   = 3'd1,
    READ   = 3'd2,
    MODIFY = 3'd3,
    WRITE  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SIZE-1:0]        cnt_q, cnt_d;
  logic                   op_q, op_d;
  logic [SIZE-1:0]        adr_q, adr_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic                   req_ready_q, req_ready_d;
  logic [SIZE-1:0]        rd_adr_q, rd_adr_d;
  logic [SIZE-1:0]        write_adr_q, write_adr_d;
  logic                   write_en_q, write_en_d;
  logic [BUCKET_SIZE-1:0] write_data_q, write_data_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_err_q, resp_err_d;
  logic                   init_done_q, init_done_d;

  logic [BUCKET_SIZE-1:0] mask;
  logic [BUCKET_SIZE-1:0] new_flags;
  logic                   hit;
  logic                   slot_bad;
  logic                   err;

  always_comb begin
    mask      = BUCKET_SIZE'(1) << slot_q;
    hit       = |(rd_flag_i & mask);
    slot_bad  = (32'(slot_q) >= 32'(BUCKET_SIZE));
    new_flags = op_q ? (rd_flag_i & ~mask) : (rd_flag_i | mask);
    err       = slot_bad | (op_q ? ~hit : hit);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    adr_d        = adr_q;
    slot_d       = slot_q;
    req_ready_d  = req_ready_q;
    rd_adr_d     = rd_adr_q;
    write_adr_d  = write_adr_q;
    write_en_d   = 1'b0;
    write_data_d = write_data_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    init_done_d  = init_done_q;

    case (state_q)
      CLEAR: begin
        // Outputs are registered, so the sweep ends once the last address is on the write port.
        if (write_en_q && (&write_adr_q)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          req_ready_d = 1'b1;
        end else begin
          write_en_d   = 1'b1;
          write_adr_d  = cnt_q;
          write_data_d = '0;
          cnt_d        = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (clear_i) begin
          state_d     = CLEAR;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          init_done_d = 1'b0;
        end else if (req_if.req_valid_i && req_ready_q) begin
          state_d     = READ;
          op_d        = req_if.req_op_i;
          adr_d       = req_if.req_adr_i;
          slot_d      = req_if.req_slot_i;
          rd_adr_d    = req_if.req_adr_i;
          req_ready_d = 1'b0;
        end
      end
      READ: begin
        state_d = MODIFY;
      end
      MODIFY: begin
        state_d      = WRITE;
        write_en_d   = ~err;
        write_adr_d  = adr_q;
        write_data_d = new_flags;
        resp_valid_d = 1'b1;
        resp_err_d   = err;
      end
      WRITE: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = CLEAR;
        cnt_d       = '0;
        req_ready_d = 1'b0;
        init_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      op_q         <= 1'b0;
      adr_q        <= '0;
      slot_q       <= '0;
      req_ready_q  <= 1'b0;
      rd_adr_q     <= '0;
      write_adr_q  <= '0;
      write_en_q   <= 1'b0;
      write_data_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      adr_q        <= adr_d;
      slot_q       <= slot_d;
      req_ready_q  <= req_ready_d;
      rd_adr_q     <= rd_adr_d;
      write_adr_q  <= write_adr_d;
      write_en_q   <= write_en_d;
      write_data_q <= write_data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      init_done_q  <= init_done_d;
    end
  end

  assign req_if.req_ready_o  = req_ready_q;
  assign req_if.resp_valid_o = resp_valid_q;
  assign req_if.resp_err_o   = resp_err_q;
  assign rd_adr_o            = rd_adr_q;
  assign write_adr_o         = write_adr_q;
  assign write_en_o          = write_en_q;
  assign write_is_valid_o    = write_data_q;
  assign init_done_o         = init_done_q;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_flag_writer.sv
// Directed bench for flag_writer with a registered flag-memory model; responses
// are checked against an expected queue by an independent monitor.
module tb_flag_writer;
  localparam int SIZE = 4;
  localparam int BS   = 4;
  localparam int SW   = 2;
  localparam int W    = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_i = 1'b0;
  always #5 clk = ~clk;

  flag_writer_if #(.SIZE(SIZE), .BUCKET_SIZE(BS), .SLOT_W(SW)) req_if ();

  logic [SIZE-1:0] rd_adr_o, write_adr_o;
  logic [BS-1:0]   rd_flag_i, write_is_valid_o;
  logic            write_en_o, init_done_o;
  logic [2:0]      dbg_state_o;

  flag_writer #(.SIZE(SIZE), .BUCKET_SIZE(BS), .SLOT_W(SW)) dut (
    .clk              (clk),
    .reset            (reset),
    .clear_i          (clear_i),
    .req_if           (req_if),
    .rd_adr_o         (rd_adr_o),
    .rd_flag_i        (rd_flag_i),
    .write_adr_o      (write_adr_o),
    .write_en_o       (write_en_o),
    .write_is_valid_o (write_is_valid_o),
    .init_done_o      (init_done_o),
    .dbg_state_o      (dbg_state_o)
  );

  // Flag memory model: registered read, starts full of garbage.
  logic [BS-1:0] mem [16] = '{default: 4'hF};
  always @(posedge clk) begin
    rd_flag_i <= mem[rd_adr_o];
    if (write_en_o) mem[write_adr_o] <= write_is_valid_o;
  end

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: {err, write_en, write_adr, write_data}
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    if (!reset && req_if.resp_valid_o) begin
      act = {req_if.resp_err_o, write_en_o, write_adr_o, write_is_valid_o};
      check("resp_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("resp", 32'(act), 32'(e));
      end
    end
  end

  // Flag writes may only come from a sweep or the WRITE step.
  always @(negedge clk) begin
    if (!reset && write_en_o)
      check("write_state", 32'(dbg_state_o == 3'd0 || dbg_state_o == 3'd4), 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Called inside cycle 0 of a sweep (the first cycle the FSM sits in CLEAR).
  task automatic check_sweep();
    logic        en_e, done_e;
    logic [3:0]  adr_e;
    logic [11:0] act, exp;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check("sweep_start_state", 32'(dbg_state_o), 32'd0);
      en_e   = (cyc >= 1 && cyc <= 16);
      adr_e  = en_e ? 4'(cyc - 1) : 4'd0;
      done_e = (cyc >= 17);
      exp = {en_e, adr_e, 4'd0, done_e, done_e, 1'b0};
      act = {write_en_o, write_en_o ? write_adr_o : 4'd0, write_en_o ? write_is_valid_o : 4'd0,
             init_done_o, req_if.req_ready_o, req_if.resp_valid_o};
      check($sformatf("sweep_cyc%0d", cyc), 32'(act), 32'(exp));
    end
  endtask

  task automatic check_mem_zero();
    logic [BS-1:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | mem[i];
    check("mem_cleared", 32'(acc), 32'd0);
  endtask

  // Entered and left on a negative edge.
  task automatic do_req(input logic op, input logic [3:0] adr, input logic [1:0] slot,
                        input logic exp_err, input logic [3:0] exp_new);
    int n;
    n = 0;
    while (!req_if.req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(req_if.req_ready_o), 32'd1);
    exp_q.push_back({exp_err, !exp_err, adr, exp_new});
    req_if.req_valid_i = 1'b1;
    req_if.req_op_i    = op;
    req_if.req_adr_i   = adr;
    req_if.req_slot_i  = slot;
    @(posedge clk);
    #1 req_if.req_valid_i = 1'b0;
    @(negedge clk);
    check("rd_adr_t1", 32'(rd_adr_o), 32'(adr));
    check("state_t1", 32'(dbg_state_o), 32'd2);
    check("ready_t1", 32'(req_if.req_ready_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("resp_valid_t3", 32'(req_if.resp_valid_o), 32'd1);
    @(negedge clk);
    check("ready_t4", 32'(req_if.req_ready_o), 32'd1);
    check("resp_valid_t4", 32'(req_if.resp_valid_o), 32'd0);
  endtask

  initial begin
    int n;
    req_if.req_valid_i = 1'b0;
    req_if.req_op_i    = 1'b0;
    req_if.req_adr_i   = '0;
    req_if.req_slot_i  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'({req_if.req_ready_o, write_en_o, req_if.resp_valid_o, req_if.resp_err_o,
                              init_done_o, rd_adr_o, write_adr_o, write_is_valid_o, dbg_state_o}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    check_sweep();
    check_mem_zero();

    // Insert / delete sequence on entry 5, then another entry
    do_req(1'b0, 4'd5, 2'd2, 1'b0, 4'b0100);
    do_req(1'b0, 4'd5, 2'd0, 1'b0, 4'b0101);
    do_req(1'b0, 4'd5, 2'd2, 1'b1, 4'b0101);
    check("mem5_after_dup_insert", 32'(mem[5]), 32'b0101);
    do_req(1'b1, 4'd5, 2'd2, 1'b0, 4'b0001);
    do_req(1'b1, 4'd5, 2'd2, 1'b1, 4'b0001);
    check("mem5_after_dup_delete", 32'(mem[5]), 32'b0001);
    do_req(1'b0, 4'd9, 2'd3, 1'b0, 4'b1000);
    check("mem9", 32'(mem[9]), 32'b1000);

    // clear_i wins over a simultaneous request
    clear_i            = 1'b1;
    req_if.req_valid_i = 1'b1;
    req_if.req_op_i    = 1'b0;
    req_if.req_adr_i   = 4'd5;
    req_if.req_slot_i  = 2'd1;
    @(posedge clk);
    #1;
    clear_i            = 1'b0;
    req_if.req_valid_i = 1'b0;
    check_sweep();
    check_mem_zero();
    do_req(1'b0, 4'd5, 2'd1, 1'b0, 4'b0010);

    // Reset in the middle of a sweep
    clear_i = 1'b1;
    @(posedge clk);
    #1 clear_i = 1'b0;
    n = 0;
    while (!(write_en_o && write_adr_o == 4'd9) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sweep_reached_9", 32'(write_en_o && write_adr_o == 4'd9), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_sweep();
    check_mem_zero();
    do_req(1'b0, 4'd3, 2'd1, 1'b0, 4'b0010);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
